uc_fsm: RTL

- Sequenced control unit that sits directly upstream of the microc datapath.
- Consumes the datapath's opcode[5:0] and z; drives s_inc, s_abs, s_inm, we3, wez and op[2:0], replacing hand-driven control.
- Adds run/single-step/halt sequencing, a sticky illegal-opcode flag and a retired-instruction counter.
- Integration requires one datapath change: pc_en as a load-enable on the datapath PC register.

---
 rtl/uc_pkg.sv | 40 ++++
 rtl/uc_decode.sv | 47 ++++
 rtl/uc_fsm.sv | 111 +++++++++++
 3 files changed

// File: rtl/uc_pkg.sv
// Shared types and encodings for the microc control unit.
// Opcode classes are matched on opcode[5:2]; opcode[1:0] is don't-care.
package uc_pkg;

    localparam logic [3:0] OPC_LI   = 4'b0000;
    localparam logic [3:0] OPC_J    = 4'b0001;
    localparam logic [3:0] OPC_JZ   = 4'b0010;
    localparam logic [3:0] OPC_JNZ  = 4'b0011;
    localparam logic [3:0] OPC_JR   = 4'b0100;
    localparam logic [3:0] OPC_NOP  = 4'b0101;
    localparam logic [3:0] OPC_HALT = 4'b0110;
    localparam logic [3:0] OPC_ILL  = 4'b0111;

    localparam logic [2:0] ALU_NONE = 3'b000;
    localparam logic [2:0] ALU_ADD  = 3'b010;
    localparam logic [2:0] ALU_SUB  = 3'b011;

    typedef enum logic [2:0] {
        StRstWait  = 3'd0,
        StRun      = 3'd1,
        StStepWait = 3'd2,
        StExec     = 3'd3,
        StHalted   = 3'd4
    } state_e;

    typedef struct packed {
        logic       s_inc;
        logic       s_abs;
        logic       s_inm;
        logic       we3;
        logic       wez;
        logic [2:0] op;
    } ctrl_t;

    // Safe control word: no writes, PC would advance by one if it were enabled.
    localparam ctrl_t CTRL_IDLE = '{
        s_inc: 1'b1, s_abs: 1'b0, s_inm: 1'b0, we3: 1'b0, wez: 1'b0, op: ALU_NONE
    };

endpackage

// File: rtl/uc_decode.sv
// Combinational opcode decoder: opcode and zero flag to datapath control word.
module uc_decode
    import uc_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic       z,
    output ctrl_t      ctrl,
    output logic       is_halt,
    output logic       is_illegal
);

    always_comb begin
        ctrl       = CTRL_IDLE;
        is_halt    = 1'b0;
        is_illegal = 1'b0;
        if (opcode[5]) begin
            ctrl.op  = opcode[4:2];
            ctrl.we3 = 1'b1;
            ctrl.wez = 1'b1;
        end else begin
            case (opcode[5:2])
                OPC_LI: begin
                    ctrl.s_inm = 1'b1;
                    ctrl.we3   = 1'b1;
                end
                OPC_J: begin
                    ctrl.s_inc = 1'b0;
                    ctrl.s_abs = 1'b1;
                end
                OPC_JZ: begin
                    ctrl.s_inc = ~z;
                    ctrl.s_abs = 1'b1;
                end
                OPC_JNZ: begin
                    ctrl.s_inc = z;
                    ctrl.s_abs = 1'b1;
                end
                OPC_JR:   ctrl.s_inc = 1'b0;
                OPC_NOP:  ;
                OPC_HALT: is_halt = 1'b1;
                OPC_ILL:  is_illegal = 1'b1;
                default:  ;
            endcase
        end
    end

endmodule

// File: rtl/uc_fsm.sv
// Sequenced control unit for the microc datapath: run / single-step / halt,
// sticky illegal-opcode flag and a saturating retired-instruction counter.
module uc_fsm
    import uc_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       opcode,
    input  logic             z,
    input  logic             run_mode,
    input  logic             step,
    input  logic             resume,
    output logic             s_inc,
    output logic             s_abs,
    output logic             s_inm,
    output logic             we3,
    output logic             wez,
    output logic [2:0]       op,
    output logic             pc_en,
    output logic             halted,
    output logic             illegal,
    output logic [CNT_W-1:0] instr_count
);

    state_e state_q;
    logic   step_d;
    ctrl_t  dec_ctrl;
    ctrl_t  ctrl_out;
    logic   is_halt;
    logic   is_illegal;
    logic   executing;

    uc_decode u_decode (
        .opcode     (opcode),
        .z          (z),
        .ctrl       (dec_ctrl),
        .is_halt    (is_halt),
        .is_illegal (is_illegal)
    );

    assign executing = (state_q == StRun) || (state_q == StExec);

    // z feeds straight through the decoder so conditional jumps resolve this cycle.
    always_comb begin
        ctrl_out = CTRL_IDLE;
        if (executing) begin
            ctrl_out = dec_ctrl;
        end
    end

    assign s_inc  = ctrl_out.s_inc;
    assign s_abs  = ctrl_out.s_abs;
    assign s_inm  = ctrl_out.s_inm;
    assign we3    = ctrl_out.we3;
    assign wez    = ctrl_out.wez;
    assign op     = ctrl_out.op;
    assign pc_en  = executing;
    assign halted = (state_q == StHalted);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StRstWait;
            step_d      <= 1'b0;
            illegal     <= 1'b0;
            instr_count <= '0;
        end else begin
            step_d <= step;
            if (executing) begin
                if (is_illegal) begin
                    illegal <= 1'b1;
                end
                if (instr_count != {CNT_W{1'b1}}) begin
                    instr_count <= instr_count + CNT_W'(1);
                end
            end
            case (state_q)
                StRstWait: state_q <= run_mode ? StRun : StStepWait;
                StRun: begin
                    if (is_halt) begin
                        state_q <= StHalted;
                    end else if (!run_mode) begin
                        state_q <= StStepWait;
                    end
                end
                StStepWait: begin
                    if (run_mode) begin
                        state_q <= StRun;
                    end else if (step && !step_d) begin
                        state_q <= StExec;
                    end
                end
                StExec: begin
                    if (is_halt) begin
                        state_q <= StHalted;
                    end else begin
                        state_q <= run_mode ? StRun : StStepWait;
                    end
                end
                StHalted: begin
                    if (resume) begin
                        state_q <= run_mode ? StRun : StStepWait;
                    end
                end
                default: state_q <= StRstWait;
            endcase
        end
    end

endmodule
